// File: rtl/fir_mac_sequencer_if.sv
// Sample, delay-line and result signals of the FIR MAC sequencer.
// The sequencer uses the slave view; the environment uses the master view.
interface fir_mac_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     in_sample;
    logic                        load;
    logic signed [WIDTH-1:0]     mem_in;
    logic [7:0]                  counter;
    logic signed [WIDTH-1:0]     tap_in;
    logic signed [WIDTH-1:0]     coef_in;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_sample, tap_in, coef_in, out_ready,
        output in_ready, load, mem_in, counter, out_valid, out_data
    );

    modport master (
        output in_valid, in_sample, tap_in, coef_in, out_ready,
        input  in_ready, load, mem_in, counter, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR control/datapath: accepts a sample, shifts it into the delay line, walks
// all taps through a registered multiplier and returns a scaled, saturated sum.
module fir_mac_sequencer #(
    parameter int LENGTH    = 64,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_mac_sequencer_if.slave   bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      r_state;
    logic                        r_load;
    logic signed [WIDTH-1:0]     r_mem_in;
    logic [7:0]                  r_counter;
    logic signed [PW-1:0]        r_prod;
    logic                        r_prod_v;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_out_data;

    logic signed [PW-1:0]        w_mult;
    logic signed [ACC_WIDTH-1:0] w_acc_sum;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic                        w_in_range;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_mult = bus.tap_in * bus.coef_in;

    // Includes the pending product so DRAIN can register the final result directly.
    assign w_acc_sum = r_prod_v ? (r_acc + ACC_WIDTH'(r_prod)) : r_acc;
    assign w_shifted = w_acc_sum >>> SHIFT;

    // In range when every bit above the output sign bit matches it.
    assign w_in_range = (&w_shifted[ACC_WIDTH-1:OUT_WIDTH-1]) ||
                        (~|w_shifted[ACC_WIDTH-1:OUT_WIDTH-1]);
    assign w_sat = w_in_range ? w_shifted[OUT_WIDTH-1:0] :
                   (w_shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                           : {1'b0, {(OUT_WIDTH-1){1'b1}}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_load      <= 1'b0;
            r_mem_in    <= '0;
            r_counter   <= '0;
            r_prod      <= '0;
            r_prod_v    <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (r_prod_v) begin
                r_acc <= w_acc_sum;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mem_in <= bus.in_sample;
                        r_load   <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_load    <= 1'b0;
                    r_counter <= '0;
                    r_acc     <= '0;
                    r_state   <= S_MAC;
                end
                S_MAC: begin
                    r_prod   <= w_mult;
                    r_prod_v <= 1'b1;
                    if (r_counter == 8'(LENGTH - 1)) begin
                        r_counter <= '0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_counter <= r_counter + 8'd1;
                    end
                end
                S_DRAIN: begin
                    r_prod_v    <= 1'b0;
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.load      = r_load;
    assign bus.mem_in    = r_mem_in;
    assign bus.counter   = r_counter;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer with LENGTH=4, SHIFT=0, coef[k]=k+1,
// a behavioural delay line and separate result and timing monitors.
module tb_fir_mac_sequencer;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.WIDTH(16), .OUT_WIDTH(16)) bus ();

    fir_mac_sequencer #(
        .LENGTH(L), .WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16), .SHIFT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Delay line with its own reset; coefficient ROM is counter+1
    logic signed [15:0] dl [L];
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < L; k++) dl[k] <= '0;
        end else if (bus.load) begin
            dl[0] <= bus.mem_in;
            for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
        end
    end
    assign bus.tap_in  = dl[bus.counter[1:0]];
    assign bus.coef_in = $signed({8'd0, bus.counter}) + 16'sd1;

    int cyc     = 0;
    int rst_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) rst_cnt <= rst_cnt + 1;
    end

    // Result monitor: pops expectations, applies backpressure, checks stability
    logic signed [15:0] exp_q [$];
    int                 stall_cfg = 0;
    int                 stall_left = 0;
    logic               have_prev = 1'b0;
    logic signed [15:0] prev_data = '0;
    logic signed [15:0] exp_v;

    always @(negedge clk) begin
        #2;
        if (bus.out_valid) begin
            if (have_prev) chk("out_data_stable", int'(bus.out_data), int'(prev_data));
            prev_data = bus.out_data;
            have_prev = 1'b1;
            if (stall_left > 0) begin
                stall_left--;
                bus.out_ready = 1'b0;
            end else if (!bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("out_data", int'(bus.out_data), int'(exp_v));
                    $display("result out_data=%0d expected=%0d", bus.out_data, exp_v);
                end
                bus.out_ready = 1'b1;
            end
        end else begin
            bus.out_ready = 1'b0;
            stall_left    = stall_cfg;
            have_prev     = 1'b0;
        end
    end

    // Timing monitor: d counts cycles after the accept edge (d=0 is LOAD)
    int   acc_cyc   = 0;
    int   mon_epoch = 0;
    logic have_acc  = 1'b0;
    logic in_flight = 1'b0;
    logic ov_prev   = 1'b0;
    int   d;

    always @(negedge clk) begin
        #2;
        if (mon_epoch != rst_cnt) begin
            mon_epoch = rst_cnt;
            in_flight = 1'b0;
            have_acc  = 1'b0;
        end else if (in_flight) begin
            d = cyc - acc_cyc;
            if (d <= 5) begin
                chk("load_pulse", int'(bus.load), (d == 0) ? 1 : 0);
                chk("counter_seq", int'(bus.counter), (d >= 1 && d <= 4) ? d - 1 : 0);
                chk("in_ready_busy", int'(bus.in_ready), 0);
            end
            if (bus.out_valid && !ov_prev) begin
                chk("out_valid_latency", d, L + 2);
                in_flight = 1'b0;
            end else if (d > 60) begin
                chk("out_valid_timeout", d, L + 2);
                in_flight = 1'b0;
            end
        end
        if (bus.in_valid && bus.in_ready && rst) begin
            if (have_acc) chk("accept_spacing_ok", int'((cyc + 1 - acc_cyc) >= L + 4), 1);
            acc_cyc   = cyc + 1;
            have_acc  = 1'b1;
            in_flight = 1'b1;
        end
        ov_prev = bus.out_valid;
    end

    // Offers a sample (in_valid left high) and returns after the accept edge
    task automatic send(input logic signed [15:0] s, input logic signed [15:0] e, input bit push);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", n, 0);
        end else begin
            if (push) exp_q.push_back(e);
            $display("send sample=%0d expect=%0d push=%0d", s, e, push);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    logic signed [15:0] imp_s [5] = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    logic signed [15:0] imp_e [5] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0};
    logic signed [15:0] stp_e [5] = '{16'sd100, 16'sd300, 16'sd600, 16'sd1000, 16'sd1000};
    logic signed [15:0] neg_e [4] = '{16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768};

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_load", int'(bus.load), 0);
        chk("rst_counter", int'(bus.counter), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_mem_in", int'(bus.mem_in), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", int'(bus.in_ready), 1);

        // Impulse with in_valid held continuously
        stall_cfg = 0;
        for (int i = 0; i < 5; i++) send(imp_s[i], imp_e[i], 1'b1);
        drain();

        // Step with 3-cycle backpressure on every result
        stall_cfg = 3;
        for (int i = 0; i < 5; i++) send(16'sd100, stp_e[i], 1'b1);
        drain();

        // Saturation at both rails
        stall_cfg = 0;
        for (int i = 0; i < 4; i++) send(16'sd32767, 16'sd32767, 1'b1);
        for (int i = 0; i < 4; i++) send(-16'sd32768, neg_e[i], 1'b1);
        drain();

        // Reset in the middle of MAC
        send(16'sd7, 16'sd0, 1'b0);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.counter != 8'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_counter_2", int'(bus.counter), 2);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_counter", int'(bus.counter), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        rst = 1'b1;
        @(negedge clk);
        send(16'sd1, 16'sd1, 1'b1);
        send(16'sd0, 16'sd2, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
